// File: rtl/control_fsm.sv
// Sequencer for per-pixel histogram equalisation: load, pad, then per-pixel
// window/histogram/CDF loop until every pixel is done, then show.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   re       - synchronous active-high reset, highest priority
//   load_c   - image load complete
//   pad_i_c  - image padding complete
//   wf       - window fetch complete for the current pixel
//   hc       - histogram computation complete
//   cdf_c    - CDF/remap complete for the current pixel
//   load_i   - request: load image
//   pad_i    - request: pad image
//   re_win   - request: read window around current pixel
//   h_s      - request: start histogram
//   cdf_s    - request: start CDF/remap
//   show_i   - processing finished, output image valid
//   pixcel   - index of current pixel, 0..NPIX
module control_fsm #(
    parameter int IMG_W = 150,
    parameter int IMG_H = 150
) (
    input  logic        clk,
    input  logic        re,
    input  logic        load_c,
    input  logic        pad_i_c,
    input  logic        wf,
    input  logic        hc,
    input  logic        cdf_c,
    output logic        load_i,
    output logic        pad_i,
    output logic        re_win,
    output logic        h_s,
    output logic        cdf_s,
    output logic        show_i,
    output logic [14:0] pixcel
);

    localparam int          NPIX = IMG_W * IMG_H;
    localparam logic [14:0] PEND = 15'(NPIX);
    localparam logic [14:0] LAST = 15'(NPIX - 1);

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        PAD  = 3'd1,
        WIN  = 3'd2,
        HIST = 3'd3,
        CDF  = 3'd4,
        SHOW = 3'd5
    } state_t;

    state_t     state;
    logic [5:0] req;

    // One-hot request vector for a state:
    // {load_i, pad_i, re_win, h_s, cdf_s, show_i}
    function automatic logic [5:0] dec(input state_t s);
        logic [5:0] r;
        case (s)
            LOAD:    r = 6'b100000;
            PAD:     r = 6'b010000;
            WIN:     r = 6'b001000;
            HIST:    r = 6'b000100;
            CDF:     r = 6'b000010;
            SHOW:    r = 6'b000001;
            default: r = 6'b100000;
        endcase
        return r;
    endfunction

    // Requests are registered alongside the state so they always
    // reflect the state entered on the same edge.
    always_ff @(posedge clk) begin
        if (re) begin
            state  <= LOAD;
            req    <= dec(LOAD);
            pixcel <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_c) begin
                        state <= PAD;
                        req   <= dec(PAD);
                    end
                end
                PAD: begin
                    if (pad_i_c) begin
                        state <= WIN;
                        req   <= dec(WIN);
                    end
                end
                WIN: begin
                    if (wf) begin
                        state <= HIST;
                        req   <= dec(HIST);
                    end
                end
                HIST: begin
                    if (hc) begin
                        state <= CDF;
                        req   <= dec(CDF);
                    end
                end
                CDF: begin
                    if (cdf_c) begin
                        // Saturate at NPIX so the index never wraps
                        if (pixcel < PEND) begin
                            pixcel <= pixcel + 15'd1;
                        end
                        if (pixcel >= LAST) begin
                            state <= SHOW;
                            req   <= dec(SHOW);
                        end else begin
                            state <= WIN;
                            req   <= dec(WIN);
                        end
                    end
                end
                SHOW: begin
                    state <= SHOW;
                    req   <= dec(SHOW);
                end
                default: begin
                    // Illegal encodings fall back to the start
                    state <= LOAD;
                    req   <= dec(LOAD);
                end
            endcase
        end
    end

    assign {load_i, pad_i, re_win, h_s, cdf_s, show_i} = req;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: reset, the load/pad/pixel-loop sequence,
// ignored and simultaneous completion inputs, full image run, reset abort.
module tb_control_fsm;

    logic        clk;
    logic        re;
    logic        load_c;
    logic        pad_i_c;
    logic        wf;
    logic        hc;
    logic        cdf_c;
    logic        load_i;
    logic        pad_i;
    logic        re_win;
    logic        h_s;
    logic        cdf_s;
    logic        show_i;
    logic [14:0] pixcel;

    int n_chk;
    int n_fail;

    localparam logic [5:0] O_LOAD = 6'b100000;
    localparam logic [5:0] O_PAD  = 6'b010000;
    localparam logic [5:0] O_WIN  = 6'b001000;
    localparam logic [5:0] O_HIST = 6'b000100;
    localparam logic [5:0] O_CDF  = 6'b000010;
    localparam logic [5:0] O_SHOW = 6'b000001;

    // Input vector bits: {re, load_c, pad_i_c, wf, hc, cdf_c}
    localparam logic [5:0] I_RE  = 6'b100000;
    localparam logic [5:0] I_LD  = 6'b010000;
    localparam logic [5:0] I_PD  = 6'b001000;
    localparam logic [5:0] I_WF  = 6'b000100;
    localparam logic [5:0] I_HC  = 6'b000010;
    localparam logic [5:0] I_CDF = 6'b000001;
    localparam logic [5:0] I_ALL = 6'b011111;

    control_fsm dut (
        .clk     (clk),
        .re      (re),
        .load_c  (load_c),
        .pad_i_c (pad_i_c),
        .wf      (wf),
        .hc      (hc),
        .cdf_c   (cdf_c),
        .load_i  (load_i),
        .pad_i   (pad_i),
        .re_win  (re_win),
        .h_s     (h_s),
        .cdf_s   (cdf_s),
        .show_i  (show_i),
        .pixcel  (pixcel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {load_i, pad_i, re_win, h_s, cdf_s, show_i};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive a vector for one rising edge, starting and ending on a falling edge
    task automatic pulse(input logic [5:0] v);
        {re, load_c, pad_i_c, wf, hc, cdf_c} = v;
        @(negedge clk);
        {re, load_c, pad_i_c, wf, hc, cdf_c} = '0;
    endtask

    logic [5:0] extra;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        {re, load_c, pad_i_c, wf, hc, cdf_c} = 6'b100000;
        @(negedge clk);
        @(negedge clk);
        re = 1'b0;

        chk("reset_outs", 32'(outs()), 32'(O_LOAD));
        chk("reset_pix", 32'(pixcel), 32'd0);

        pulse(6'b000000);
        chk("load_idle", 32'(outs()), 32'(O_LOAD));
        pulse(I_PD | I_WF | I_HC | I_CDF);
        chk("load_ignore", 32'(outs()), 32'(O_LOAD));

        pulse(I_LD);
        chk("load_to_pad", 32'(outs()), 32'(O_PAD));
        pulse(I_LD | I_WF);
        chk("pad_ignore", 32'(outs()), 32'(O_PAD));
        pulse(I_PD);
        chk("pad_to_win", 32'(outs()), 32'(O_WIN));
        pulse(I_LD | I_PD);
        chk("win_spurious", 32'(outs()), 32'(O_WIN));

        pulse(I_WF | I_HC);
        chk("wf_hc_state", 32'(outs()), 32'(O_HIST));
        chk("wf_hc_pix", 32'(pixcel), 32'd0);
        pulse(6'b000000);
        chk("hist_hold", 32'(outs()), 32'(O_HIST));
        pulse(I_HC);
        chk("hist_to_cdf", 32'(outs()), 32'(O_CDF));
        chk("cdf_pix0", 32'(pixcel), 32'd0);
        pulse(I_CDF);
        chk("cdf_to_win", 32'(outs()), 32'(O_WIN));
        chk("pix_one", 32'(pixcel), 32'd1);

        for (int i = 1; i < 100; i++) begin
            pulse(I_WF);
            pulse(I_HC);
            pulse(I_CDF);
        end
        chk("pix_100", 32'(pixcel), 32'd100);
        pulse(I_WF);
        chk("hist_at_100", 32'(outs()), 32'(O_HIST));
        pulse(I_RE | I_HC);
        chk("abort_outs", 32'(outs()), 32'(O_LOAD));
        chk("abort_pix", 32'(pixcel), 32'd0);

        // Full image with spurious completions sprinkled through
        pulse(I_LD);
        pulse(I_PD);
        chk("full_start", 32'(outs()), 32'(O_WIN));
        for (int i = 0; i < 22500; i++) begin
            if (i % 100 == 0) pulse(I_LD | I_PD);
            extra = (i % 5 == 0) ? (I_LD | I_PD) : 6'b000000;
            pulse(I_WF | extra);
            extra = (i % 7 == 0) ? (I_LD | I_PD | I_WF | I_CDF) : 6'b000000;
            pulse(I_HC | extra);
            if (i == 22499) begin
                chk("last_cdf", 32'(outs()), 32'(O_CDF));
                chk("last_pix", 32'(pixcel), 32'd22499);
            end
            extra = (i % 11 == 0) ? (I_LD | I_PD | I_WF | I_HC) : 6'b000000;
            pulse(I_CDF | extra);
            if (i % 4500 == 1234) begin
                chk("loop_outs", 32'(outs()), 32'(O_WIN));
                chk("loop_pix", 32'(pixcel), 32'(i + 1));
            end
        end
        chk("show_outs", 32'(outs()), 32'(O_SHOW));
        chk("show_pix", 32'(pixcel), 32'd22500);
        pulse(I_ALL);
        pulse(I_CDF);
        chk("show_hold", 32'(outs()), 32'(O_SHOW));
        chk("show_pix_hold", 32'(pixcel), 32'd22500);
        pulse(I_RE);
        chk("show_reset", 32'(outs()), 32'(O_LOAD));
        chk("show_reset_pix", 32'(pixcel), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
